seg7_display_driver: RTL



---
 rtl/seg7_pkg.sv | 57 +++++
 rtl/seg7_glyph.sv | 19 +
 rtl/seg7_display_driver.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph table, FSM state encoding and nibble-to-glyph lookup
// for the multi-digit 7-segment driver.
// Glyphs are active-low, bit order gfedcba (bit 6 = g, bit 0 = a).
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0011000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Hex-capable lookup; decimal digits are just the 0..9 subset.
  function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
    logic [6:0] g;
    g = GLYPH_BLANK;
    case (nibble)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      4'hF: g = GLYPH_F;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: one digit's glyph from a nibble, with blank and dash overrides.
// Ports: nibble (4b value), blank (force all-off), dash (force '-', wins over
// blank), glyph (7b active-low gfedcba). Purely combinational.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = glyph_of(nibble);
    if (blank) glyph = GLYPH_BLANK;
    if (dash)  glyph = GLYPH_DASH;
  end

endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: multi-digit active-low 7-segment driver with load
// handshake, sequential shift-add-3 decimal conversion or direct hex,
// leading-zero blanking and overflow dashes; holds last image between updates.
// Ports: clk, rst (sync, active-high); value/load/mode/blank_lz request side;
// seg (digit i at seg[7i+6:7i], digit 0 rightmost), busy, done (1-cycle pulse
// with the new image), overflow (committed image is all dashes).
// Latency accept->seg: hex 2 cycles, decimal WIDTH+2; load ignored while busy.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  blank_lz,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BW   = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  // Value padded so hex nibbles above WIDTH-1 read as zero and bits above
  // the display range can be tested for hex overflow.
  localparam int PADW = (WIDTH > BW) ? WIDTH : BW;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      sh;        // latched value; shifted out MSB-first in decimal
  logic [BW-1:0]         bcd;
  logic [BW-1:0]         bcd_adj;
  logic                  ovf;       // sticky: a bit left the top BCD nibble
  logic [CW-1:0]         cnt;
  logic                  mode_q;
  logic                  blz_q;

  logic [PADW-1:0]       vpad;
  logic                  hex_ovf;
  logic                  img_ovf;
  logic [BW-1:0]         nibs;
  logic [DIGITS-1:0]     dig_blank;
  logic [7*DIGITS-1:0]   glyphs;

  assign busy = (state != ST_IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (load) state_nxt = mode ? ST_COMMIT : ST_SHIFT;
      ST_SHIFT:  if (cnt == CW'(1)) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- shift-add-3 correction ----------------
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // ---------------- image selection ----------------
  assign vpad    = PADW'(sh);
  assign hex_ovf = |(vpad >> BW);
  assign img_ovf = mode_q ? hex_ovf : ovf;
  assign nibs    = mode_q ? vpad[BW-1:0] : bcd;

  // Blank every digit above the most significant nonzero one; digit 0 always
  // shows so that a zero value reads "0".
  always_comb begin : blank_scan
    logic seen;
    seen      = 1'b0;
    dig_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen         = seen | (nibs[4*i +: 4] != 4'd0);
      dig_blank[i] = blz_q && !img_ovf && (i != 0) && !seen;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_glyph u_glyph (
      .nibble (nibs[4*g +: 4]),
      .blank  (dig_blank[g]),
      .dash   (img_ovf),
      .glyph  (glyphs[7*g +: 7])
    );
  end

  // ---------------- datapath / committed outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sh       <= '0;
      bcd      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      blz_q    <= 1'b0;
      seg      <= '1;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            sh     <= value;
            mode_q <= mode;
            blz_q  <= blank_lz;
            bcd    <= '0;
            ovf    <= 1'b0;
            cnt    <= CW'(WIDTH);
          end
        end
        ST_SHIFT: begin
          bcd <= {bcd_adj[BW-2:0], sh[WIDTH-1]};
          ovf <= ovf | bcd_adj[BW-1];
          sh  <= sh << 1;
          cnt <= cnt - CW'(1);
        end
        ST_COMMIT: begin
          seg      <= glyphs;
          overflow <= img_ovf;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
